// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor elevator controller with latched calls, SCAN scheduling and timed doors.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS  = 4,
    parameter int MOVE_CYCLES = 3,
    parameter int DOOR_CYCLES = 2,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  r,
    output logic                  g
);
    localparam int MCW = $clog2(MOVE_CYCLES + 1);
    localparam int DCW = $clog2(DOOR_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
    state_t                r_state;
    logic [FLOOR_W-1:0]    r_floor;
    logic                  r_dir;
    logic                  r_moving;
    logic                  r_door;
    logic [NUM_FLOORS-1:0] r_pend;
    logic [MCW-1:0]        r_mcnt;
    logic [DCW-1:0]        r_dcnt;
    logic                  w_move_done;
    logic [FLOOR_W-1:0]    w_next_floor;
    logic [FLOOR_W-1:0]    w_ref;
    logic                  w_above;
    logic                  w_below;
    logic                  w_here;
    logic                  w_dir;
    logic                  w_hold;
    logic                  w_open;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    assign w_move_done  = r_state == MOVE && r_mcnt == MCW'(MOVE_CYCLES - 1);
    assign w_next_floor = r_dir ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
    // decisions are taken from the floor the car will occupy after this edge
    assign w_ref        = w_move_done ? w_next_floor : r_floor;
    assign w_here       = r_pend[w_ref];
    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pend[i] && i > int'(w_ref)) w_above = 1'b1;
            if (r_pend[i] && i < int'(w_ref)) w_below = 1'b1;
        end
    end
    // SCAN: keep heading while work lies ahead, otherwise turn toward what remains
    assign w_dir  = (w_ref == FLOOR_W'(NUM_FLOORS - 1)) ? 1'b0 :
                    (w_ref == '0) ? 1'b1 :
                    (w_above && w_below) ? r_dir :
                    w_above ? 1'b1 : w_below ? 1'b0 : r_dir;
    assign w_hold = r_state == DOOR && req[r_floor];
    assign w_open = w_here && (r_state == IDLE || w_move_done);
    assign w_set  = req & ~((r_state == DOOR) ? NUM_FLOORS'(1) << r_floor : '0);
    assign w_clr  = w_open ? NUM_FLOORS'(1) << w_ref : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_floor  <= '0;
            r_dir    <= 1'b1;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
            r_pend   <= '0;
            r_mcnt   <= '0;
            r_dcnt   <= '0;
        end else begin
            r_pend <= (r_pend | w_set) & ~w_clr;
            case (r_state)
                IDLE: begin
                    if (w_here) begin
                        r_state <= DOOR;
                        r_door  <= 1'b1;
                        r_dcnt  <= '0;
                        r_dir   <= w_dir;
                    end else if (w_above || w_below) begin
                        r_state  <= MOVE;
                        r_moving <= 1'b1;
                        r_mcnt   <= '0;
                        r_dir    <= w_dir;
                    end
                end
                MOVE: begin
                    if (w_move_done) begin
                        r_floor <= w_next_floor;
                        r_mcnt  <= '0;
                        if (w_here) begin
                            r_state  <= DOOR;
                            r_moving <= 1'b0;
                            r_door   <= 1'b1;
                            r_dcnt   <= '0;
                        end else begin
                            r_dir <= w_dir;
                        end
                    end else begin
                        r_mcnt <= r_mcnt + MCW'(1);
                    end
                end
                DOOR: begin
                    if (w_hold) begin
                        r_dcnt <= '0;
                    end else if (r_dcnt == DCW'(DOOR_CYCLES - 1)) begin
                        r_door <= 1'b0;
                        r_dir  <= w_dir;
                        if (w_above || w_below) begin
                            r_state  <= MOVE;
                            r_moving <= 1'b1;
                            r_mcnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + DCW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign cur_floor = r_floor;
    assign dir_up    = r_dir;
    assign moving    = r_moving;
    assign door_open = r_door;
    assign pending   = r_pend;
    assign r         = ~r_door;
    assign g         = r_door;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: scoreboard bench comparing the controller to a countdown-based reference model.
module tb_elevator_ctrl_n;
    localparam int NF = 4;
    localparam int MC = 3;
    localparam int DC = 2;
    localparam logic [10:0] RST_VAL = 11'b00_1_0_0_0000_1_0;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] req = '0;
    logic [1:0]    cur_floor;
    logic          dir_up, moving, door_open, r, g;
    logic [NF-1:0] pending;
    int            checks = 0;
    int            errors = 0;
    logic [10:0]   q[$];
    // reference model: mode 0 idle, 1 travelling, 2 door open; m_left = cycles remaining in the phase
    int            m_floor, m_mode, m_left;
    bit            m_dir;
    bit            m_pend[NF];

    elevator_ctrl_n #(.NUM_FLOORS(NF), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .cur_floor(cur_floor), .dir_up(dir_up),
        .moving(moving), .door_open(door_open), .pending(pending), .r(r), .g(g)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] actual();
        return {cur_floor, dir_up, moving, door_open, pending, r, g};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_floor = 0;
        m_mode = 0;
        m_left = 0;
        m_dir = 1'b1;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endfunction

    function automatic bit choose(input int f);
        bit above = 1'b0;
        bit below = 1'b0;
        foreach (m_pend[i]) begin
            if (m_pend[i] && i > f) above = 1'b1;
            if (m_pend[i] && i < f) below = 1'b1;
        end
        if (f == NF - 1) return 1'b0;
        if (f == 0) return 1'b1;
        if (above && below) return m_dir;
        if (above) return 1'b1;
        if (below) return 1'b0;
        return m_dir;
    endfunction

    function automatic logic [10:0] m_expect();
        logic [NF-1:0] pv;
        foreach (m_pend[i]) pv[i] = m_pend[i];
        return {2'(m_floor), m_dir, m_mode == 1, m_mode == 2, pv, m_mode != 2, m_mode == 2};
    endfunction

    function automatic void m_step(input logic [NF-1:0] rq);
        int  clr = -1;
        int  f0 = m_floor;
        int  md0 = m_mode;
        bit  any = 1'b0;
        foreach (m_pend[i]) any |= m_pend[i];
        if (m_mode == 0) begin
            if (m_pend[m_floor]) begin
                m_dir = choose(m_floor);
                m_mode = 2;
                m_left = DC;
                clr = m_floor;
            end else if (any) begin
                m_dir = choose(m_floor);
                m_mode = 1;
                m_left = MC;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_floor += m_dir ? 1 : -1;
                if (m_pend[m_floor]) begin
                    m_mode = 2;
                    m_left = DC;
                    clr = m_floor;
                end else begin
                    m_dir = choose(m_floor);
                    m_left = MC;
                end
            end
        end else begin
            if (rq[m_floor]) m_left = DC;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_dir = choose(m_floor);
                    m_mode = any ? 1 : 0;
                    m_left = MC;
                end
            end
        end
        for (int i = 0; i < NF; i++) begin
            if (rq[i] && !(md0 == 2 && i == f0)) m_pend[i] = 1'b1;
            if (i == clr) m_pend[i] = 1'b0;
        end
    endfunction

    task automatic tick(input logic [NF-1:0] rq);
        @(negedge clk);
        reset = 1'b1;
        req = rq;
        m_step(rq);
        q.push_back(m_expect());
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick('0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        m_reset();
        #1;
        chk("async_reset", actual(), RST_VAL);
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) chk("in_reset", actual(), RST_VAL);
        else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow at %0t: got empty queue required an entry", $time);
        end else chk("cycle", actual(), q.pop_front());
    end

    initial begin
        m_reset();
        do_reset(3);
        idle_ticks(10);
        tick(4'b0001);
        idle_ticks(6);
        tick(4'b1000);
        idle_ticks(16);
        tick(4'b0001);
        idle_ticks(30);
        tick(4'b1000);
        idle_ticks(5);
        tick(4'b0101);
        idle_ticks(40);
        tick(4'b0100);
        idle_ticks(7);
        for (int i = 0; i < 3; i++) tick(4'b0100);
        idle_ticks(6);
        tick(4'b0001);
        idle_ticks(2);
        do_reset(2);
        idle_ticks(5);
        for (int i = 0; i < 700; i++) begin
            logic [NF-1:0] rq;
            for (int b = 0; b < NF; b++) rq[b] = ($urandom_range(0, 7) == 0);
            if (i == 350) do_reset(2);
            tick(rq);
        end
        idle_ticks(40);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
